// File: rtl/ddr3_pixel_reader.sv
// ddr3_pixel_reader
// Avalon-MM burst read master that streams a stored frame out of DDR3 as
// 256-bit words. It issues fixed-length read bursts and buffers the returned
// data in an internal FIFO. That FIFO feeds a valid/ready output stream.
//
// A burst is only requested once FIFO space for the whole burst is reserved.
// Space counts as reserved when it holds a word or when a word is still
// outstanding. Because of this, read data is never dropped and never stalled.
//
// Ports
//   ddr3_clk, ddr3_clk_reset     sole clock; synchronous active-high reset
//   start                        one-cycle pulse that begins a frame read
//   ddr3_read_address/read/
//   ddr3_burstcount              Avalon read command (word address)
//   ddr3_waitrequest             command not accepted this cycle
//   ddr3_readdata/datavalid      returned read data
//   out_data/out_valid/out_ready output stream (FIFO head)
//   busy                         frame in progress
//   frame_done                   one-cycle pulse after the final pop
//   error                        sticky: read data arrived with nothing outstanding
module ddr3_pixel_reader #(
  parameter int unsigned burst_len     = 8,
  parameter int unsigned num_words     = 21600,
  parameter logic [31:0] start_address = 32'h3600_0000,
  parameter int unsigned fifo_depth    = 32
) (
  input  logic         ddr3_clk,
  input  logic         ddr3_clk_reset,
  input  logic         start,
  output logic [26:0]  ddr3_read_address,
  output logic         ddr3_read,
  output logic [7:0]   ddr3_burstcount,
  input  logic         ddr3_waitrequest,
  input  logic [255:0] ddr3_readdata,
  input  logic         ddr3_readdatavalid,
  output logic [255:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_done,
  output logic         error
);

  localparam int unsigned AW        = $clog2(fifo_depth);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned NumBursts = num_words / burst_len;
  localparam int unsigned BW        = $clog2(NumBursts + 1);
  localparam int unsigned PW        = $clog2(num_words + 1);

  typedef enum logic [1:0] {StIdle, StCheck, StReq, StDrain} state_e;

  state_e           state_q;
  logic             read_q;
  logic [26:0]      addr_q;
  logic [BW-1:0]    bursts_q;
  logic [PW-1:0]    popped_q;
  logic             frame_done_q;
  logic             error_q;

  logic [CW-1:0]    fifo_count_q;
  logic [CW-1:0]    outstanding_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [255:0]     mem_q [fifo_depth];

  logic             push;
  logic             pop;
  logic             accept;
  logic [CW:0]      reserved_next;
  logic             credit_ok;

  // Words arriving with nothing outstanding are dropped and flagged.
  assign push      = ddr3_readdatavalid && (outstanding_q != '0);
  assign pop       = out_valid && out_ready;
  assign accept    = read_q && !ddr3_waitrequest;

  // One extra bit so the sum of the counters and a burst cannot wrap.
  assign reserved_next = {1'b0, fifo_count_q} + {1'b0, outstanding_q} + (CW + 1)'(burst_len);
  assign credit_ok     = reserved_next <= (CW + 1)'(fifo_depth);

  assign ddr3_read_address = addr_q;
  assign ddr3_read         = read_q;
  assign ddr3_burstcount   = 8'(burst_len);
  assign out_data          = mem_q[rd_ptr_q];
  assign out_valid         = fifo_count_q != '0;
  assign busy              = state_q != StIdle;
  assign frame_done        = frame_done_q;
  assign error             = error_q;

  // Request sequencing. ddr3_read is registered and high exactly in StReq.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_clk_reset) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      addr_q       <= '0;
      bursts_q     <= '0;
      popped_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (pop) begin
        popped_q <= popped_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // A start landing on the frame_done cycle is ignored.
          if (start && !frame_done_q) begin
            addr_q   <= start_address[31:5];
            bursts_q <= '0;
            popped_q <= '0;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          if (credit_ok) begin
            read_q  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (!ddr3_waitrequest) begin
            read_q   <= 1'b0;
            addr_q   <= addr_q + 27'(burst_len);
            bursts_q <= bursts_q + 1'b1;
            state_q  <= (bursts_q == BW'(NumBursts - 1)) ? StDrain : StCheck;
          end
        end
        StDrain: begin
          if (pop && (popped_q == PW'(num_words - 1))) begin
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO occupancy, credit accounting and error flag.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_clk_reset) begin
      fifo_count_q  <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      error_q       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
      outstanding_q <= outstanding_q + (accept ? CW'(burst_len) : '0) - (push ? CW'(1) : '0);
      if (ddr3_readdatavalid && (outstanding_q == '0)) begin
        error_q <= 1'b1;
      end
    end
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge ddr3_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ddr3_readdata;
    end
  end

  // The credit rule makes a push into a full FIFO impossible.
  always @(posedge ddr3_clk) begin
    if (!ddr3_clk_reset && push) begin
      assert (fifo_count_q < CW'(fifo_depth));
    end
  end

endmodule
